// File: rtl/pipe_stage_elastic_pkg.sv
// Shared constants for the elastic pipeline stage: occupancy encodings and default payload width.
package pearl_pipe_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts cycles with inc_i high and sticks at all-ones.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_d = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready pipeline stage built as a 2-entry skid buffer (main + skid slot),
// with flush, optional payload clearing, occupancy report and a back-pressure counter.
module pipe_stage_elastic
  import pearl_pipe_pkg::*;
#(
  parameter int WIDTH          = DEFAULT_WIDTH,
  parameter bit CLEAR_ON_FLUSH = 1'b1,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [1:0]       occupancy_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  logic             main_v_q, main_v_d;
  logic             skid_v_q, skid_v_d;
  logic [WIDTH-1:0] main_d_q, main_d_d;
  logic [WIDTH-1:0] skid_d_q, skid_d_d;
  logic             in_fire;
  logic             out_fire;

  // Ready depends only on the skid register, so downstream ready never reaches upstream combinationally.
  assign in_ready_o = ~skid_v_q;
  assign in_fire    = in_valid_i & ~skid_v_q;
  assign out_fire   = main_v_q & out_ready_i;

  always_comb begin
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    main_d_d = main_d_q;
    skid_d_d = skid_d_q;
    if (flush_i) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
      if (CLEAR_ON_FLUSH) begin
        main_d_d = '0;
        skid_d_d = '0;
      end
    end else if (!main_v_q) begin
      if (in_fire) begin
        main_v_d = 1'b1;
        main_d_d = in_data_i;
      end
    end else if (!skid_v_q) begin
      if (out_fire) begin
        if (in_fire) begin
          main_d_d = in_data_i;
        end else begin
          main_v_d = 1'b0;
        end
      end else if (in_fire) begin
        skid_v_d = 1'b1;
        skid_d_d = in_data_i;
      end
    end else if (out_fire) begin
      main_d_d = skid_d_q;
      skid_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      main_d_q <= '0;
      skid_d_q <= '0;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      main_d_q <= main_d_d;
      skid_d_q <= skid_d_d;
    end
  end

  assign out_valid_o = main_v_q;
  assign out_data_o  = main_d_q;

  always_comb begin
    case ({main_v_q, skid_v_q})
      2'b11:   occupancy_o = OCC_FULL;
      2'b10:   occupancy_o = OCC_ONE;
      default: occupancy_o = OCC_EMPTY;
    endcase
  end

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (main_v_q & ~out_ready_i),
    .cnt_o (stall_cnt_o)
  );

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Scoreboard bench for pipe_stage_elastic: accepted payloads are queued and matched against deliveries.
module tb_pipe_stage_elastic;

  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             flush_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] in_data_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] out_data_o;
  logic [1:0]       occupancy_o;
  logic [CNT_W-1:0] stall_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [WIDTH-1:0] sb[$];

  pipe_stage_elastic #(
    .WIDTH          (WIDTH),
    .CLEAR_ON_FLUSH (1'b1),
    .CNT_W          (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .occupancy_o (occupancy_o),
    .stall_cnt_o (stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // One clock: bookkeeping on the falling edge (inputs stable), then return 1ns past the rising edge.
  task automatic tick();
    logic [WIDTH-1:0] exp;
    @(negedge clk);
    if (out_valid_o && out_ready_i) begin
      exp = (sb.size() > 0) ? sb.pop_front() : 32'hBAD0_BAD0;
      check_val("sb_out_data", out_data_o, exp);
    end
    if (flush_i) begin
      sb.delete();
    end else if (in_valid_i && in_ready_o) begin
      sb.push_back(in_data_i);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_in_ready"}, {31'b0, in_ready_o}, 32'd1);
    check_val({tag, "_out_valid"}, {31'b0, out_valid_o}, 32'd0);
    check_val({tag, "_out_data"}, out_data_o, 32'd0);
    check_val({tag, "_occ"}, {30'b0, occupancy_o}, 32'd0);
    check_val({tag, "_stall"}, {28'b0, stall_cnt_o}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; in_data_i = '0; out_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst = 1'b0;

    // Single transfer
    out_ready_i = 1'b1; in_valid_i = 1'b1; in_data_i = 32'hDEADBEEF;
    tick();
    in_valid_i = 1'b0;
    check_val("t1_valid", {31'b0, out_valid_o}, 32'd1);
    check_val("t1_data", out_data_o, 32'hDEADBEEF);
    check_val("t1_occ1", {30'b0, occupancy_o}, 32'd1);
    check_val("t1_ready", {31'b0, in_ready_o}, 32'd1);
    tick();
    check_val("t1_occ0", {30'b0, occupancy_o}, 32'd0);

    // Streaming with no bubbles
    for (int i = 1; i <= 8; i++) begin
      in_valid_i = 1'b1; in_data_i = i;
      tick();
      check_val("t2_valid", {31'b0, out_valid_o}, 32'd1);
      check_val("t2_data", out_data_o, i);
      check_val("t2_ready", {31'b0, in_ready_o}, 32'd1);
    end
    in_valid_i = 1'b0;
    tick();
    check_val("t2_drained", {30'b0, occupancy_o}, 32'd0);

    // Back-pressure fills the skid slot
    out_ready_i = 1'b0;
    in_valid_i = 1'b1; in_data_i = 32'hA;
    tick();
    in_data_i = 32'hB;
    tick();
    check_val("t3_occ2", {30'b0, occupancy_o}, 32'd2);
    check_val("t3_ready0", {31'b0, in_ready_o}, 32'd0);
    in_data_i = 32'hC;
    tick();
    check_val("t3_hold_occ", {30'b0, occupancy_o}, 32'd2);
    check_val("t3_hold_data", out_data_o, 32'hA);
    out_ready_i = 1'b1;
    tick();
    check_val("t3_b_main", out_data_o, 32'hB);
    check_val("t3_ready1", {31'b0, in_ready_o}, 32'd1);
    tick();
    in_valid_i = 1'b0;
    check_val("t3_c_main", out_data_o, 32'hC);
    tick();
    check_val("t3_drained", {30'b0, occupancy_o}, 32'd0);

    // Flush while full, upstream offering 0x55
    out_ready_i = 1'b0;
    in_valid_i = 1'b1; in_data_i = 32'h11;
    tick();
    in_data_i = 32'h22;
    tick();
    check_val("t4_occ2", {30'b0, occupancy_o}, 32'd2);
    in_data_i = 32'h55; flush_i = 1'b1;
    tick();
    flush_i = 1'b0; in_valid_i = 1'b0;
    check_val("t4_valid0", {31'b0, out_valid_o}, 32'd0);
    check_val("t4_occ0", {30'b0, occupancy_o}, 32'd0);
    check_val("t4_ready1", {31'b0, in_ready_o}, 32'd1);
    check_val("t4_data0", out_data_o, 32'd0);
    // Flush with one entry held and a real in_fire of 0x66 the same cycle
    in_valid_i = 1'b1; in_data_i = 32'h44;
    tick();
    in_data_i = 32'h66; flush_i = 1'b1;
    tick();
    flush_i = 1'b0; in_valid_i = 1'b0;
    check_val("t4b_occ0", {30'b0, occupancy_o}, 32'd0);
    check_val("t4b_data0", out_data_o, 32'd0);
    tick();
    check_val("t4b_no_ghost", {31'b0, out_valid_o}, 32'd0);

    // Stall counter saturation after a fresh reset
    rst = 1'b1; #2; rst = 1'b0;
    sb.delete();
    check_val("t5_cnt_rst", {28'b0, stall_cnt_o}, 32'd0);
    out_ready_i = 1'b0; in_valid_i = 1'b1; in_data_i = 32'h77;
    tick();
    in_valid_i = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      check_val("t5_cnt", {28'b0, stall_cnt_o}, (k > 15) ? 32'd15 : k);
    end
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check_val("t5_after_flush", {28'b0, stall_cnt_o}, 32'd15);
    tick();
    check_val("t5_idle_hold", {28'b0, stall_cnt_o}, 32'd15);
    rst = 1'b1; #2; rst = 1'b0;
    check_val("t5_cnt_cleared", {28'b0, stall_cnt_o}, 32'd0);

    // Async reset mid-operation, between clock edges
    out_ready_i = 1'b0; in_valid_i = 1'b1; in_data_i = 32'h1;
    tick();
    in_data_i = 32'h2;
    tick();
    in_valid_i = 1'b0;
    check_val("t6_occ2", {30'b0, occupancy_o}, 32'd2);
    check_val("t6_cnt1", {28'b0, stall_cnt_o}, 32'd1);
    #1; rst = 1'b1; #1;
    check_reset_outputs("t6");
    rst = 1'b0;
    sb.delete();
    out_ready_i = 1'b1; in_valid_i = 1'b1; in_data_i = 32'h99;
    tick();
    in_valid_i = 1'b0;
    check_val("t6_post_data", out_data_o, 32'h99);
    tick();
    check_val("t6_post_occ", {30'b0, occupancy_o}, 32'd0);
    check_val("t6_sb_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
